// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the S-R latch command sequencer.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_INVALID = 2'b10;

  // Counter width that can hold the larger of the two terminal counts.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Multi-flop synchronizer for one asynchronous feedback bit; clears to 0 on reset.
module sr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Command sequencer for an S-R latch: pulses S or R, then confirms via synchronized Q/Q_not.
// Optional build macro SR_DRV_SKIP_REDUNDANT_EN skips the pulse when the latch already holds the target.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  output logic       s_out,
  output logic       r_out,
  input  logic       q_in,
  input  logic       q_not_in,
  output logic       q_sync,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int CW = cnt_width(PULSE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set_q, set_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          inv_q, inv_d;
  logic          qn_sync;
  logic          match, invalid;

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
    .clk (clk), .rst (rst), .d (q_in), .q (q_sync)
  );

  sr_sync #(.STAGES(SYNC_STAGES)) u_sync_qn (
    .clk (clk), .rst (rst), .d (q_not_in), .q (qn_sync)
  );

  assign match   = (q_sync == set_q) && (qn_sync == ~set_q);
  assign invalid = (q_sync == qn_sync);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    s_d     = s_q;
    r_d     = r_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          set_d  = cmd_set;
          code_d = ERR_NONE;
          cnt_d  = '0;
          inv_d  = 1'b0;
`ifdef SR_DRV_SKIP_REDUNDANT_EN
          if ((q_sync == cmd_set) && (qn_sync == ~cmd_set)) begin
            state_d = WAIT;
          end else begin
            state_d = PULSE;
            s_d     = cmd_set;
            r_d     = ~cmd_set;
          end
`else
          state_d = PULSE;
          s_d     = cmd_set;
          r_d     = ~cmd_set;
`endif
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT;
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = '0;
          inv_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        // Invalid feedback is checked before the timeout so it wins a tie.
        if (match) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (invalid && inv_q) begin
          err_d   = 1'b1;
          code_d  = ERR_INVALID;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          inv_d = invalid;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      set_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      inv_q   <= inv_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule
